// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - ASCII "R<n>:<hex>" line decoder producing register-write strobes
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_rx_data    received byte, qualified by i_rx_valid
//   i_rx_valid   one-cycle pulse per received byte
//   o_wr_stb     one-cycle pulse, o_wr_addr/o_wr_data hold a new command
//   o_wr_addr    decoded register number (held until the next strobe)
//   o_wr_data    decoded data, right-justified, zero-extended (held)
//   o_err        one-cycle pulse, a malformed line was discarded
//   o_busy       a line is partially received
module uart_cmd_rx #(
  parameter int DATA_W  = 16,
  parameter int NUM_NIB = DATA_W / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_wr_stb,
  output logic [1:0]        o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_err,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(NUM_NIB + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REG,
    S_COLON,
    S_DATA,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        addr_q, addr_d;      // register number of the line in progress
  logic [1:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_stb_q, wr_stb_d;
  logic              err_q, err_d;

  logic       is_term;
  logic       is_hex;
  logic [3:0] nib;
  logic       is_regnum;

  // Character classification. Bytes with bit 7 set never match any class.
  always_comb begin
    is_term   = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
    is_hex    = 1'b0;
    nib       = 4'h0;
    is_regnum = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h33);
    if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = i_rx_data[3:0];
    end else if ((i_rx_data >= 8'h41 && i_rx_data <= 8'h46) ||
                 (i_rx_data >= 8'h61 && i_rx_data <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = i_rx_data[3:0] + 4'd9;   // 'A'/'a' have low nibble 1 -> 10
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_stb_d  = 1'b0;
    err_d     = 1'b0;
    if (i_rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (i_rx_data == 8'h52 || i_rx_data == 8'h72) state_d = S_REG;
          else if (!is_term)                            state_d = S_ERR;
        end
        S_REG: begin
          if (is_regnum) begin
            state_d = S_COLON;
            addr_d  = i_rx_data[1:0];
          end else if (is_term) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        S_COLON: begin
          if (i_rx_data == 8'h3A) begin
            state_d = S_DATA;
            shift_d = '0;
            cnt_d   = '0;
          end else if (is_term) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        S_DATA: begin
          if (is_hex) begin
            if (cnt_q < CNT_W'(NUM_NIB)) begin
              shift_d = (shift_q << 4) | DATA_W'(nib);
              cnt_d   = cnt_q + 1'b1;
            end else begin
              state_d = S_ERR;
            end
          end else if (is_term) begin
            state_d = S_IDLE;
            if (cnt_q != '0) begin
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = shift_q;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          if (is_term) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_stb_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_stb_q  <= wr_stb_d;
      err_q     <= err_d;
    end
  end

  assign o_wr_stb  = wr_stb_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_err     = err_q;
  assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx against a line-level reference model
module tb_uart_cmd_rx;

  localparam int DATA_W  = 16;
  localparam int NUM_NIB = DATA_W / 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              o_wr_stb;
  logic [1:0]        o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic              o_err;
  logic              o_busy;

  uart_cmd_rx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_wr_stb   (o_wr_stb),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_err      (o_err),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: bytes of the current line, and last committed command.
  logic [7:0]        line[$];
  logic [1:0]        m_addr = 2'd0;
  logic [DATA_W-1:0] m_data = '0;
  bit                gap_en = 1'b0;
  int                n_stb  = 0;
  int                n_err  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - int'("0");
    if (b >= "A" && b <= "F") return int'(b) - int'("A") + 10;
    if (b >= "a" && b <= "f") return int'(b) - int'("a") + 10;
    return -1;
  endfunction

  // Judges a complete line (terminator excluded) as a whole.
  function automatic bit parse_line(input logic [7:0] l[$], output logic [1:0] a,
                                    output logic [DATA_W-1:0] d);
    int v;
    a = 2'd0;
    d = '0;
    if (l.size() < 4 || l.size() > 3 + NUM_NIB) return 1'b0;
    if (l[0] != "R" && l[0] != "r") return 1'b0;
    if (l[1] < "0" || l[1] > "3") return 1'b0;
    a = 2'(int'(l[1]) - int'("0"));
    if (l[2] != ":") return 1'b0;
    for (int i = 3; i < l.size(); i++) begin
      v = hexval(l[i]);
      if (v < 0) return 1'b0;
      d = DATA_W'(d * 16 + v);
    end
    return 1'b1;
  endfunction

  task automatic check_outputs(input string where, input bit exp_stb, input bit exp_err);
    chk({where, ".stb"},  32'(o_wr_stb),  32'(exp_stb));
    chk({where, ".err"},  32'(o_err),     32'(exp_err));
    chk({where, ".busy"}, 32'(o_busy),    32'(line.size() != 0));
    chk({where, ".addr"}, 32'(o_wr_addr), 32'(m_addr));
    chk({where, ".data"}, 32'(o_wr_data), 32'(m_data));
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit                exp_stb, exp_err;
    logic [1:0]        a;
    logic [DATA_W-1:0] d;
    int                gap;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
    exp_stb = 1'b0;
    exp_err = 1'b0;
    if (b == 8'h0D || b == 8'h0A) begin
      if (line.size() != 0) begin
        if (parse_line(line, a, d)) begin
          exp_stb = 1'b1;
          m_addr  = a;
          m_data  = d;
          n_stb++;
        end else begin
          exp_err = 1'b1;
          n_err++;
        end
      end
      line.delete();
    end else begin
      line.push_back(b);
    end
    check_outputs("byte", exp_stb, exp_err);
    if (gap_en) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        i_rx_data = 8'($urandom);
        @(posedge clk);
        #1;
        check_outputs("idle", 1'b0, 1'b0);
      end
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    i_rx_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    line.delete();
    m_addr = 2'd0;
    m_data = '0;
    check_outputs("reset", 1'b0, 1'b0);
  endtask

  // One random line: mostly well-formed, with assorted corruptions.
  task automatic random_line();
    string      hexchars = "0123456789abcdefABCDEF";
    logic [7:0] q[$];
    int         mode, ndig, pos;
    mode = $urandom_range(0, 6);
    ndig = $urandom_range(1, NUM_NIB);
    if (mode == 3) ndig = ($urandom_range(0, 1) == 0) ? 0 : NUM_NIB + 1;
    q.push_back(($urandom_range(0, 1) == 0) ? 8'h52 : 8'h72);
    q.push_back(8'(int'("0") + $urandom_range(0, 3)));
    q.push_back(":");
    for (int i = 0; i < ndig; i++) q.push_back(hexchars[$urandom_range(0, 21)]);
    if (mode == 4) begin
      pos = $urandom_range(0, q.size() - 1);
      q[pos] = 8'($urandom);
    end else if (mode == 5) begin
      q[1] = 8'(int'("4") + $urandom_range(0, 5));
    end else if (mode == 6) begin
      pos = $urandom_range(0, q.size() - 1);
      q[pos] = 8'h80 | 8'($urandom);
    end
    foreach (q[i]) send_byte(q[i]);
    send_byte(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A);
    if ($urandom_range(0, 3) == 0) send_byte(8'h0A);
  endtask

  initial begin
    rst        = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("por", 1'b0, 1'b0);
    rst = 1'b0;

    // Directed cases with idle gaps between bytes.
    gap_en = 1'b1;
    send_str("R2:1A3F"); send_byte(8'h0D);
    chk("dir.addr2", 32'(o_wr_addr), 32'd2);
    chk("dir.data1A3F", 32'(o_wr_data), 32'h1A3F);
    send_str("r1:7"); send_byte(8'h0A); send_byte(8'h0D);
    chk("dir.data7", 32'(o_wr_data), 32'h0007);
    send_str("R3:12345"); send_byte(8'h0D);
    send_str("R4:00");    send_byte(8'h0D);
    send_str("R1-00");    send_byte(8'h0D);
    send_str("R1:");      send_byte(8'h0D);
    send_str("R1:0G");    send_byte(8'h0D);
    send_byte(8'h0D);
    send_byte(8'hD2);     send_str("R1:5"); send_byte(8'h0A);
    chk("dir.counts", 32'(n_stb * 16 + n_err), 32'(2 * 16 + 6));

    // Back-to-back stream, i_rx_valid every cycle.
    gap_en = 1'b0;
    send_str("R0:FFFF"); send_byte(8'h0D);
    chk("b2b.first", 32'({o_wr_addr, o_wr_data}), 32'({2'd0, 16'hFFFF}));
    send_str("R1:0001"); send_byte(8'h0D);
    chk("b2b.second", 32'({o_wr_addr, o_wr_data}), 32'({2'd1, 16'h0001}));

    // Reset in the middle of a line.
    send_str("R2:AB");
    do_reset();
    send_str("R1:C"); send_byte(8'h0D);
    chk("rst.result", 32'({o_wr_addr, o_wr_data}), 32'({2'd1, 16'h000C}));

    // Randomized lines, gaps toggled randomly.
    for (int n = 0; n < 300; n++) begin
      gap_en = ($urandom_range(0, 1) == 1);
      random_line();
      if (n % 97 == 50) begin
        send_str("r3:");
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
